fetch_stage: RTL and testbench

Instruction-fetch front end that produces the instruction, PC+2 and fetch-error flag consumed by the IF/ID pipeline register. It holds the PC and runs a request/response handshake with a variable-latency instruction memory (cache). It holds its output while the pipeline stalls, and discards or redirects fetches on a taken branch or jump. Decoded halt freezes fetching until reset.

---
 rtl/fetch_stage.sv | 139 +++++++++++++
 tb/tb_fetch_stage.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, runs a one-outstanding request/response
// handshake with the instruction memory, and presents one fetch at a time to IF/ID.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INSN = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] inst_mem_addr,
  output logic        inst_mem_rd,
  input  logic        inst_mem_stall,
  input  logic        inst_mem_done,
  input  logic [15:0] inst_mem_rdata,
  input  logic        inst_mem_err,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt_ID,
  output logic [15:0] instruction,
  output logic [15:0] pcAdd2,
  output logic        inst_mem_err_out,
  output logic        fetch_valid,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_REQ,
    S_WAIT,
    S_DRAIN,
    S_VALID,
    S_HALTED
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ibuf_q, ibuf_d;
  logic [15:0] ipc2_q, ipc2_d;
  logic        ebuf_q, ebuf_d;

  assign inst_mem_addr = pc_q;

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    ibuf_d           = ibuf_q;
    ipc2_d           = ipc2_q;
    ebuf_d           = ebuf_q;
    inst_mem_rd      = 1'b0;
    fetch_valid      = 1'b0;
    instruction      = NOP_INSN;
    inst_mem_err_out = 1'b0;
    pcAdd2           = ipc2_q;
    halted           = 1'b0;

    case (state_q)
      S_REQ: begin
        if (redirect) begin
          pc_d = redirect_pc;
        end else if (halt_ID) begin
          state_d = S_HALTED;
        end else begin
          inst_mem_rd = 1'b1;
          if (!inst_mem_stall) state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (inst_mem_done) begin
          if (redirect) begin
            pc_d    = redirect_pc;
            state_d = S_REQ;
          end else begin
            ibuf_d  = inst_mem_rdata;
            ebuf_d  = inst_mem_err;
            ipc2_d  = pc_q + 16'd2;
            pc_d    = pc_q + 16'd2;
            state_d = S_VALID;
          end
        end else if (redirect) begin
          pc_d    = redirect_pc;
          state_d = S_DRAIN;
        end
      end

      // The request in flight belongs to the old path; its response is dropped.
      S_DRAIN: begin
        if (redirect) pc_d = redirect_pc;
        if (inst_mem_done) state_d = S_REQ;
      end

      S_VALID: begin
        fetch_valid      = 1'b1;
        instruction      = ibuf_q;
        inst_mem_err_out = ebuf_q;
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = S_REQ;
        end else if (!stall) begin
          state_d = (halt_ID || ebuf_q) ? S_HALTED : S_REQ;
        end
      end

      S_HALTED: begin
        halted = 1'b1;
      end

      default: begin
        state_d = S_REQ;
      end
    endcase

    // The reset cycle presents reset values even before the state register clears.
    if (rst) begin
      inst_mem_rd      = 1'b0;
      fetch_valid      = 1'b0;
      instruction      = NOP_INSN;
      inst_mem_err_out = 1'b0;
      pcAdd2           = 16'h0000;
      halted           = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      ibuf_q  <= NOP_INSN;
      ipc2_q  <= 16'h0000;
      ebuf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ibuf_q  <= ibuf_d;
      ipc2_q  <= ipc2_d;
      ebuf_q  <= ebuf_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage with hand-computed expectations.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic [15:0] inst_mem_addr;
  logic        inst_mem_rd;
  logic        inst_mem_stall;
  logic        inst_mem_done;
  logic [15:0] inst_mem_rdata;
  logic        inst_mem_err;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt_ID;
  logic [15:0] instruction;
  logic [15:0] pcAdd2;
  logic        inst_mem_err_out;
  logic        fetch_valid;
  logic        halted;

  int checks;
  int failures;

  fetch_stage #(.RESET_PC(16'h0000), .NOP_INSN(16'h0800)) dut (
    .clk              (clk),
    .rst              (rst),
    .inst_mem_addr    (inst_mem_addr),
    .inst_mem_rd      (inst_mem_rd),
    .inst_mem_stall   (inst_mem_stall),
    .inst_mem_done    (inst_mem_done),
    .inst_mem_rdata   (inst_mem_rdata),
    .inst_mem_err     (inst_mem_err),
    .stall            (stall),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .halt_ID          (halt_ID),
    .instruction      (instruction),
    .pcAdd2           (pcAdd2),
    .inst_mem_err_out (inst_mem_err_out),
    .fetch_valid      (fetch_valid),
    .halted           (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Step one edge; inputs change 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst            = 1'b1;
    inst_mem_stall = 1'b0;
    inst_mem_done  = 1'b0;
    inst_mem_rdata = 16'h0000;
    inst_mem_err   = 1'b0;
    stall          = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = 16'h0000;
    halt_ID        = 1'b0;

    // Reset state
    tick();
    check("rst_valid", {31'd0, fetch_valid}, 32'd0);
    check("rst_insn", {16'd0, instruction}, 32'h0800);
    check("rst_pc2", {16'd0, pcAdd2}, 32'h0000);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_rd", {31'd0, inst_mem_rd}, 32'd0);

    // Basic fetch, zero-wait memory
    rst = 1'b0;
    settle();
    check("f1_rd", {31'd0, inst_mem_rd}, 32'd1);
    check("f1_addr", {16'd0, inst_mem_addr}, 32'h0000);
    tick();
    inst_mem_done = 1'b1; inst_mem_rdata = 16'h1234;
    settle();
    check("f1_wait_rd", {31'd0, inst_mem_rd}, 32'd0);
    check("f1_wait_valid", {31'd0, fetch_valid}, 32'd0);
    tick();
    inst_mem_done = 1'b0;
    settle();
    check("f1_valid", {31'd0, fetch_valid}, 32'd1);
    check("f1_insn", {16'd0, instruction}, 32'h1234);
    check("f1_pc2", {16'd0, pcAdd2}, 32'h0002);
    check("f1_err", {31'd0, inst_mem_err_out}, 32'd0);
    tick();
    check("f2_rd", {31'd0, inst_mem_rd}, 32'd1);
    check("f2_addr", {16'd0, inst_mem_addr}, 32'h0002);

    // Memory busy for 3 cycles: request held with constant address
    inst_mem_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) inst_mem_stall = 1'b0;
      settle();
      check($sformatf("mst_rd%0d", i), {31'd0, inst_mem_rd}, 32'd1);
      check($sformatf("mst_addr%0d", i), {16'd0, inst_mem_addr}, 32'h0002);
      tick();
    end
    check("mst_wait_rd", {31'd0, inst_mem_rd}, 32'd0);
    inst_mem_done = 1'b1; inst_mem_rdata = 16'hABCD;
    tick();
    inst_mem_done = 1'b0;

    // Pipeline stall for 4 cycles in VALID
    for (int i = 0; i < 5; i++) begin
      stall = (i < 4);
      settle();
      check($sformatf("st_valid%0d", i), {31'd0, fetch_valid}, 32'd1);
      check($sformatf("st_insn%0d", i), {16'd0, instruction}, 32'hABCD);
      check($sformatf("st_pc2%0d", i), {16'd0, pcAdd2}, 32'h0004);
      check($sformatf("st_rd%0d", i), {31'd0, inst_mem_rd}, 32'd0);
      tick();
    end
    stall = 1'b0;
    check("st_next_rd", {31'd0, inst_mem_rd}, 32'd1);
    check("st_next_addr", {16'd0, inst_mem_addr}, 32'h0004);

    // Redirect in WAIT, response two cycles later is dropped
    tick();
    redirect = 1'b1; redirect_pc = 16'h0100;
    tick();
    redirect = 1'b0;
    settle();
    check("dr_valid0", {31'd0, fetch_valid}, 32'd0);
    check("dr_rd0", {31'd0, inst_mem_rd}, 32'd0);
    tick();
    inst_mem_done = 1'b1; inst_mem_rdata = 16'h5555;
    settle();
    check("dr_valid1", {31'd0, fetch_valid}, 32'd0);
    tick();
    inst_mem_done = 1'b0;
    settle();
    check("dr_valid2", {31'd0, fetch_valid}, 32'd0);
    check("dr_insn2", {16'd0, instruction}, 32'h0800);
    check("dr_rd2", {31'd0, inst_mem_rd}, 32'd1);
    check("dr_addr2", {16'd0, inst_mem_addr}, 32'h0100);

    // Redirect coincident with done
    tick();
    inst_mem_done = 1'b1; inst_mem_rdata = 16'h5555;
    redirect = 1'b1; redirect_pc = 16'h0100;
    tick();
    inst_mem_done = 1'b0; redirect = 1'b0;
    settle();
    check("rc_valid", {31'd0, fetch_valid}, 32'd0);
    check("rc_rd", {31'd0, inst_mem_rd}, 32'd1);
    check("rc_addr", {16'd0, inst_mem_addr}, 32'h0100);

    // PC wrap at 0xFFFE
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    settle();
    check("wr_redir_rd", {31'd0, inst_mem_rd}, 32'd0);
    tick();
    redirect = 1'b0;
    settle();
    check("wr_addr", {16'd0, inst_mem_addr}, 32'hFFFE);
    tick();
    inst_mem_done = 1'b1; inst_mem_rdata = 16'h4321;
    tick();
    inst_mem_done = 1'b0;
    settle();
    check("wr_insn", {16'd0, instruction}, 32'h4321);
    check("wr_pc2", {16'd0, pcAdd2}, 32'h0000);
    tick();
    check("wr_next_rd", {31'd0, inst_mem_rd}, 32'd1);
    check("wr_next_addr", {16'd0, inst_mem_addr}, 32'h0000);

    // Error response halts fetch after consumption
    tick();
    inst_mem_done = 1'b1; inst_mem_err = 1'b1; inst_mem_rdata = 16'h7777;
    tick();
    inst_mem_done = 1'b0; inst_mem_err = 1'b0;
    settle();
    check("er_valid", {31'd0, fetch_valid}, 32'd1);
    check("er_insn", {16'd0, instruction}, 32'h7777);
    check("er_flag", {31'd0, inst_mem_err_out}, 32'd1);
    check("er_pc2", {16'd0, pcAdd2}, 32'h0002);
    tick();
    check("er_halted", {31'd0, halted}, 32'd1);
    check("er_rd", {31'd0, inst_mem_rd}, 32'd0);
    check("er_hvalid", {31'd0, fetch_valid}, 32'd0);
    check("er_hinsn", {16'd0, instruction}, 32'h0800);
    redirect = 1'b1; redirect_pc = 16'h0200;
    tick();
    redirect = 1'b0;
    tick();
    check("er_still_halted", {31'd0, halted}, 32'd1);
    check("er_still_rd", {31'd0, inst_mem_rd}, 32'd0);
    check("er_addr_kept", {16'd0, inst_mem_addr}, 32'h0002);

    // halt_ID in REQ halts immediately; redirect ignored afterwards
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    check("hi_halted0", {31'd0, halted}, 32'd0);
    check("hi_rd0", {31'd0, inst_mem_rd}, 32'd1);
    halt_ID = 1'b1;
    settle();
    check("hi_rd1", {31'd0, inst_mem_rd}, 32'd0);
    tick();
    halt_ID = 1'b0;
    redirect = 1'b1; redirect_pc = 16'h0300;
    settle();
    check("hi_halted", {31'd0, halted}, 32'd1);
    tick();
    redirect = 1'b0;
    tick();
    check("hi_halted2", {31'd0, halted}, 32'd1);
    check("hi_rd2", {31'd0, inst_mem_rd}, 32'd0);
    check("hi_addr", {16'd0, inst_mem_addr}, 32'h0000);

    // Reset during WAIT, then a late done is ignored
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("rw_wait_rd", {31'd0, inst_mem_rd}, 32'd0);
    rst = 1'b1;
    settle();
    check("rw_rst_rd", {31'd0, inst_mem_rd}, 32'd0);
    check("rw_rst_halted", {31'd0, halted}, 32'd0);
    tick();
    rst = 1'b0;
    inst_mem_done = 1'b1; inst_mem_rdata = 16'h9999;
    settle();
    check("rw_valid", {31'd0, fetch_valid}, 32'd0);
    check("rw_insn", {16'd0, instruction}, 32'h0800);
    check("rw_pc2", {16'd0, pcAdd2}, 32'h0000);
    check("rw_rd", {31'd0, inst_mem_rd}, 32'd1);
    check("rw_addr", {16'd0, inst_mem_addr}, 32'h0000);
    tick();
    inst_mem_done = 1'b0;
    settle();
    check("rw_wait_valid", {31'd0, fetch_valid}, 32'd0);
    inst_mem_done = 1'b1; inst_mem_rdata = 16'h1111;
    tick();
    inst_mem_done = 1'b0;
    settle();
    check("rw_new_valid", {31'd0, fetch_valid}, 32'd1);
    check("rw_new_insn", {16'd0, instruction}, 32'h1111);
    check("rw_new_pc2", {16'd0, pcAdd2}, 32'h0002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
